// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Optional early termination when the remaining recode digits are all zero: BOOTH_EARLY_TERM_EN.
module booth_r4_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               signed_mode_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned ExtW     = WIDTH + 2;
  localparam int unsigned NumSteps = ExtW / 2;
  localparam int unsigned AccW     = 2 * ExtW;
  localparam int unsigned ProdW    = 2 * WIDTH;
  localparam int unsigned CntW     = $clog2(NumSteps + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ExtW-1:0]     a_q, a_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic                qm1_q, qm1_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ProdW-1:0]    product_q, product_d;

  logic [ExtW-1:0]     a_ext, b_ext;
  logic [ExtW:0]       mult;
  logic [ExtW:0]       sum;
  logic [AccW-1:0]     step_acc;

  always_comb begin
    a_ext = {{2{signed_mode_i & multiplicand_i[WIDTH-1]}}, multiplicand_i};
    b_ext = {{2{signed_mode_i & multiplier_i[WIDTH-1]}}, multiplier_i};
  end

  // Booth digit select on {m[1], m[0], q-1}; multiples are ExtW+1 bits, sign-extended.
  always_comb begin
    mult = '0;
    unique case ({acc_q[1:0], qm1_q})
      3'b001, 3'b010: mult = {a_q[ExtW-1], a_q};
      3'b011:         mult = {a_q, 1'b0};
      3'b100:         mult = -{a_q, 1'b0};
      3'b101, 3'b110: mult = -{a_q[ExtW-1], a_q};
      default:        mult = '0;
    endcase
  end

  // Add into the upper half, then arithmetic shift the whole accumulator right by two.
  always_comb begin
    sum      = {acc_q[AccW-1], acc_q[AccW-1:ExtW]} + mult;
    step_acc = {sum[ExtW], sum, acc_q[ExtW-1:2]};
  end

`ifdef BOOTH_EARLY_TERM_EN
  int                  et_rem;
  logic                et_all0, et_all1, et_hit;
  logic [AccW-1:0]     et_acc;

  // Remaining multiplier bits sit in acc_q[ExtW-1-2*cnt:0]; all-equal with q-1 means only +0 digits.
  always_comb begin
    et_rem  = int'(ExtW) - 2 * int'(cnt_q);
    et_all0 = ~qm1_q;
    et_all1 = qm1_q;
    for (int i = 0; i < int'(ExtW); i++) begin
      if (i < et_rem) begin
        et_all0 = et_all0 & ~acc_q[i];
        et_all1 = et_all1 & acc_q[i];
      end
    end
    et_hit = et_all0 | et_all1;
    et_acc = $signed(acc_q) >>> (2 * (int'(NumSteps) - int'(cnt_q)));
  end
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    acc_d     = acc_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_ext;
          acc_d   = {{ExtW{1'b0}}, b_ext};
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
`ifdef BOOTH_EARLY_TERM_EN
        if (et_hit) begin
          acc_d     = et_acc;
          product_d = et_acc[ProdW-1:0];
          state_d   = StDone;
        end else begin
`else
        begin
`endif
          acc_d = step_acc;
          qm1_d = acc_q[1];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(NumSteps - 1)) begin
            product_d = step_acc[ProdW-1:0];
            state_d   = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      a_q       <= '0;
      acc_q     <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign product_o = product_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult at WIDTH=8: directed vector table plus handshake,
// reset and busy-start sequences; latency expectations follow BOOTH_EARLY_TERM_EN.
module tb_booth_r4_seq_mult;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sm;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks;
  int failures;

  booth_r4_seq_mult #(
    .WIDTH(8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .signed_mode_i (sm),
    .multiplicand_i(a),
    .multiplier_i  (b),
    .busy_o        (busy),
    .done_o        (done),
    .product_o     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Launch one op, scramble inputs after the start cycle, and observe the handshake.
  task automatic run_op(input logic s, input logic [7:0] ia, input logic [7:0] ib,
                        output logic [15:0] p, output int dcyc,
                        output logic busy_ok, output logic post_ok);
    busy_ok = 1'b1;
    post_ok = 1'b1;
    dcyc    = 0;
    p       = '0;
    @(negedge clk);
    if (busy) busy_ok = 1'b0;
    sm    = s;
    a     = ia;
    b     = ib;
    start = 1'b1;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      a     = ~ia;
      b     = ib ^ 8'h5A;
      sm    = ~s;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        dcyc = c;
        p    = product;
        break;
      end
    end
    if (dcyc != 0) begin
      @(negedge clk);
      if (done || busy || (product !== p)) post_ok = 1'b0;
    end
  endtask

  task automatic do_vec(input string name, input logic s, input logic [7:0] ia,
                        input logic [7:0] ib, input logic [15:0] exp);
    logic [15:0] p;
    int          dcyc;
    logic        bok;
    logic        pok;
    run_op(s, ia, ib, p, dcyc, bok, pok);
    chk({name, "_product"}, 32'(p), 32'(exp));
    chk({name, "_busy"}, 32'(bok), 32'd1);
    chk({name, "_post"}, 32'(pok), 32'd1);
    chk({name, "_lat_bound"}, 32'((dcyc >= 3) && (dcyc <= 7)), 32'd1);
`ifdef BOOTH_EARLY_TERM_EN
    if (ib == 8'h00) chk({name, "_latency"}, 32'(dcyc), 32'd3);
`else
    chk({name, "_latency"}, 32'(dcyc), 32'd7);
`endif
  endtask

  initial begin
    logic [15:0] p;
    int          ndone;
    int          cnt;
    logic        ok;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    int          ea;
    int          eb;

    checks   = 0;
    failures = 0;
    start    = 1'b0;
    sm       = 1'b0;
    a        = '0;
    b        = '0;
    rst_n    = 1'b0;

    vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[3]  = '{1'b1, 8'h7F, 8'hFF, 16'hFF81};
    vecs[4]  = '{1'b1, 8'h05, 8'hFD, 16'hFFF1};
    vecs[5]  = '{1'b0, 8'h5A, 8'h00, 16'h0000};
    vecs[6]  = '{1'b0, 8'h03, 8'h04, 16'h000C};
    vecs[7]  = '{1'b0, 8'h09, 8'h09, 16'h0051};
    vecs[8]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[9]  = '{1'b0, 8'h80, 8'h7F, 16'h3F80};
    vecs[10] = '{1'b1, 8'hFF, 8'h80, 16'h0080};
    vecs[11] = '{1'b0, 8'h12, 8'h34, 16'h03A8};
    vecs[12] = '{1'b1, 8'hC3, 8'h5A, 16'hEA8E};
    vecs[13] = '{1'b0, 8'hC3, 8'h5A, 16'h448E};
    vecs[14] = '{1'b1, 8'h80, 8'h00, 16'h0000};

    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 15; i++) begin
      do_vec($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Start pulse in cycle 3 while busy must be ignored.
    @(negedge clk);
    sm = 1'b0; a = 8'd3; b = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    p     = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        p = product;
      end
    end
    chk("busy_start_dones", 32'(ndone), 32'd1);
    chk("busy_start_product", 32'(p), 32'h000C);
    do_vec("after_busy", 1'b0, 8'd9, 8'd9, 16'h0051);

    // Start asserted during DONE must be ignored.
    @(negedge clk);
    sm = 1'b0; a = 8'd7; b = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("done_start_seen", 32'(done), 32'd1);
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_idle", 32'(busy), 32'd0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("done_start_no_op", 32'(ndone), 32'd0);
    chk("done_start_product", 32'(product), 32'h0038);

    // Start held high: a new op each time the FSM returns to idle.
    @(negedge clk);
    sm = 1'b0; a = 8'd5; b = 8'd6; start = 1'b1;
    ndone = 0;
    ok    = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (product !== 16'h001E) ok = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_start_count", 32'(ndone >= 3), 32'd1);
    chk("held_start_product", 32'(ok), 32'd1);
    cnt = 0;
    while (busy && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("held_start_drain", 32'(busy), 32'd0);

    // Reset in cycle 4 of an operation aborts it.
    @(negedge clk);
    sm = 1'b0; a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    do_vec("after_rst", 1'b0, 8'd2, 8'd3, 16'h0006);

    // Random sweep against an integer reference product.
    for (int n = 0; n < 100; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      ea = rs ? int'($signed(ra)) : int'(ra);
      eb = rs ? int'($signed(rb)) : int'(rb);
      do_vec($sformatf("rnd%0d", n), rs, ra, rb, 16'(ea * eb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
